// File: rtl/genesys_ldmem_pkg.sv
// rtl/genesys_ldmem_pkg.sv - shared FSM state encoding for the ldmem tile loader
package genesys_ldmem_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_TAG = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_TAG_DONE = 3'd4
    } ldmem_state_e;

endpackage

// File: rtl/ldmem_addr_gen.sv
// rtl/ldmem_addr_gen.sv - tile base and per-burst DDR address accumulators
module ldmem_addr_gen
    import genesys_ldmem_pkg::*;
#(
    parameter int ADDR_W = 42
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step_req,
    input  logic              i_step_tile,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_req_stride,
    input  logic [ADDR_W-1:0] i_tile_stride,
    output logic [ADDR_W-1:0] o_req_addr
);

    logic [ADDR_W-1:0] r_tile_base;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_tile_next;

    assign w_tile_next = r_tile_base + i_tile_stride;

    // Stepping a tile rewinds the request pointer to the new tile base.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tile_base <= '0;
            r_req_addr  <= '0;
        end else if (i_load) begin
            r_tile_base <= i_base;
            r_req_addr  <= i_base;
        end else if (i_step_tile) begin
            r_tile_base <= w_tile_next;
            r_req_addr  <= w_tile_next;
        end else if (i_step_req) begin
            r_req_addr  <= r_req_addr + i_req_stride;
        end
    end

    assign o_req_addr = r_req_addr;

endmodule

// File: rtl/ldmem_tile_loader.sv
// rtl/ldmem_tile_loader.sv - per-tile DDR burst issuer driven by the ldmem tag sync
module ldmem_tile_loader
    import genesys_ldmem_pkg::*;
#(
    parameter int TAG_W           = 1,
    parameter int ADDR_W          = 42,
    parameter int BURST_LEN_W     = 8,
    parameter int NUM_REQ_W       = 16,
    parameter int NUM_TILE_W      = 16,
    parameter int BUF_ADDR_W      = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_cfg_base_addr,
    input  logic [ADDR_W-1:0]      i_cfg_req_stride,
    input  logic [ADDR_W-1:0]      i_cfg_tile_stride,
    input  logic [BURST_LEN_W-1:0] i_cfg_burst_len,
    input  logic [NUM_REQ_W-1:0]   i_cfg_num_req,
    input  logic [NUM_TILE_W-1:0]  i_cfg_num_tiles,
    input  logic                   i_ldmem_tag_ready,
    input  logic [TAG_W-1:0]       i_ldmem_tag,
    output logic                   o_ldmem_tag_done,
    output logic                   o_rd_req_valid,
    input  logic                   i_rd_req_ready,
    output logic [ADDR_W-1:0]      o_rd_req_addr,
    output logic [BURST_LEN_W-1:0] o_rd_req_len,
    output logic [TAG_W-1:0]       o_rd_req_tag,
    input  logic                   i_rd_resp_valid,
    input  logic                   i_rd_resp_last,
    output logic                   o_buf_wr_en,
    output logic [TAG_W-1:0]       o_buf_wr_tag,
    output logic [BUF_ADDR_W-1:0]  o_buf_wr_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    ldmem_state_e           r_state;
    ldmem_state_e           w_next;

    logic [ADDR_W-1:0]      r_req_stride;
    logic [ADDR_W-1:0]      r_tile_stride;
    logic [BURST_LEN_W-1:0] r_burst_len;
    logic [NUM_REQ_W-1:0]   r_num_req;
    logic [NUM_TILE_W-1:0]  r_num_tiles;

    logic [NUM_REQ_W-1:0]   r_req_idx;
    logic [NUM_TILE_W-1:0]  r_tile_idx;
    logic [OUT_W-1:0]       r_outstanding;
    logic [BUF_ADDR_W-1:0]  r_buf_addr;
    logic [TAG_W-1:0]       r_cur_tag;
    logic                   r_err;
    logic                   r_done_zero;

    logic                   w_start_ok;
    logic                   w_tag_grab;
    logic                   w_loading;
    logic                   w_req_left;
    logic                   w_accept;
    logic                   w_resp_done;
    logic                   w_stray;
    logic                   w_last_req;
    logic                   w_last_tile;
    logic                   w_tag_done;
    logic [ADDR_W-1:0]      w_req_addr;

    assign w_start_ok  = i_start && (r_state == ST_IDLE);
    assign w_tag_grab  = (r_state == ST_WAIT_TAG) && i_ldmem_tag_ready;
    assign w_loading   = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_req_left  = r_req_idx < r_num_req;
    assign w_accept    = o_rd_req_valid && i_rd_req_ready;
    assign w_resp_done = w_loading && i_rd_resp_valid && i_rd_resp_last && (r_outstanding != '0);
    assign w_stray     = i_rd_resp_valid && (r_outstanding == '0);
    assign w_last_req  = (r_req_idx + NUM_REQ_W'(1)) == r_num_req;
    assign w_last_tile = (r_tile_idx + NUM_TILE_W'(1)) == r_num_tiles;
    assign w_tag_done  = (r_state == ST_TAG_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_start_ok && (i_cfg_num_tiles != '0)) w_next = ST_WAIT_TAG;
            ST_WAIT_TAG: if (i_ldmem_tag_ready) w_next = ST_ISSUE;
            ST_ISSUE:    if (!w_req_left || (w_accept && w_last_req)) w_next = ST_DRAIN;
            ST_DRAIN:    if (r_outstanding == '0) w_next = ST_TAG_DONE;
            ST_TAG_DONE: w_next = w_last_tile ? ST_IDLE : ST_WAIT_TAG;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_stride  <= '0;
            r_tile_stride <= '0;
            r_burst_len   <= '0;
            r_num_req     <= '0;
            r_num_tiles   <= '0;
            r_req_idx     <= '0;
            r_tile_idx    <= '0;
            r_outstanding <= '0;
            r_buf_addr    <= '0;
            r_cur_tag     <= '0;
            r_err         <= 1'b0;
            r_done_zero   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_req_stride  <= i_cfg_req_stride;
                r_tile_stride <= i_cfg_tile_stride;
                r_burst_len   <= i_cfg_burst_len;
                r_num_req     <= i_cfg_num_req;
                r_num_tiles   <= i_cfg_num_tiles;
                r_tile_idx    <= '0;
            end else if (w_tag_done) begin
                r_tile_idx    <= r_tile_idx + NUM_TILE_W'(1);
            end

            if (w_tag_grab) begin
                r_req_idx  <= '0;
                r_buf_addr <= '0;
                r_cur_tag  <= i_ldmem_tag;
            end else begin
                if (w_accept) r_req_idx <= r_req_idx + NUM_REQ_W'(1);
                if (o_buf_wr_en) r_buf_addr <= r_buf_addr + BUF_ADDR_W'(1);
            end

            // Accept and burst completion in the same cycle cancel out.
            if (w_accept && !w_resp_done) begin
                r_outstanding <= r_outstanding + OUT_W'(1);
            end else if (!w_accept && w_resp_done) begin
                r_outstanding <= r_outstanding - OUT_W'(1);
            end

            r_err       <= (r_err && !w_start_ok) || w_stray;
            r_done_zero <= w_start_ok && (i_cfg_num_tiles == '0);
        end
    end

    ldmem_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_start_ok),
        .i_step_req    (w_accept),
        .i_step_tile   (w_tag_done),
        .i_base        (i_cfg_base_addr),
        .i_req_stride  (r_req_stride),
        .i_tile_stride (r_tile_stride),
        .o_req_addr    (w_req_addr)
    );

    assign o_rd_req_valid   = (r_state == ST_ISSUE) && w_req_left && (r_outstanding < MAX_OUT);
    assign o_rd_req_addr    = w_req_addr;
    assign o_rd_req_len     = r_burst_len;
    assign o_rd_req_tag     = r_cur_tag;
    assign o_buf_wr_en      = w_loading && i_rd_resp_valid;
    assign o_buf_wr_tag     = r_cur_tag;
    assign o_buf_wr_addr    = r_buf_addr;
    assign o_ldmem_tag_done = w_tag_done;
    assign o_done           = r_done_zero || (w_tag_done && w_last_tile);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_err            = r_err;

endmodule
